switch_port_4: RTL and testbench

- 4-port packet switch; each port has an ingress byte stream and an egress byte stream.
- Each ingress packet is routed to the egress port named in its header byte.
- Per-ingress FIFOs; per-egress round-robin arbitration with packet-level grant hold.
- Each port is bundled as one design_if instance (clk, reset plus the per-port signals below) in the top-level integration.

---
 rtl/switch_port_4.sv | 201 ++++++++++++++++++++
 tb/tb_switch_port_4.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_4.sv
// switch_port_4: 4-port byte-stream packet switch with per-ingress FIFOs and per-egress
// round-robin packet arbitration. Optional macro SELF_DROP_EN discards self-routed packets.
module switch_port_4 #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          ip_valid,
    input  logic [3:0]          ip_sop,
    input  logic [3:0]          ip_eop,
    input  logic [4*DATA_W-1:0] ip_data,
    output logic [3:0]          ip_suspend,
    output logic [3:0]          op_valid,
    output logic [3:0]          op_sop,
    output logic [3:0]          op_eop,
    output logic [4*DATA_W-1:0] op_data,
    input  logic [3:0]          op_suspend
);
    localparam int unsigned NP = 4;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_W + 2;  // stored entry {sop, eop, data}
`ifdef SELF_DROP_EN
    localparam bit SELF_DROP = 1'b1;
`else
    localparam bit SELF_DROP = 1'b0;
`endif

    logic [EW-1:0]     mem_q [NP][FIFO_DEPTH];
    logic [EW-1:0]     mem_d [NP][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q [NP], wr_ptr_d [NP];
    logic [AW-1:0]     rd_ptr_q [NP], rd_ptr_d [NP];
    logic [CW-1:0]     cnt_q [NP], cnt_d [NP];
    logic [1:0]        src_q [NP], src_d [NP];
    logic [1:0]        rr_q [NP], rr_d [NP];
    logic [NP-1:0]     in_pkt_q, in_pkt_d, drop_q, drop_d, busy_q, busy_d;
    logic [NP-1:0]     ip_suspend_q, ip_suspend_d;
    logic [NP-1:0]     pop_vld_q, pop_vld_d, pop_sop_q, pop_sop_d, pop_eop_q, pop_eop_d;
    logic [DATA_W-1:0] pop_data_q [NP], pop_data_d [NP];
    logic [NP-1:0]     op_valid_q, op_valid_d, op_sop_q, op_sop_d, op_eop_q, op_eop_d;
    logic [DATA_W-1:0] op_data_q [NP], op_data_d [NP];

    logic [EW-1:0]     head [NP];
    logic [NP-1:0]     empty, full, wr, pop, held;
    logic [AW-1:0]     prev_ptr;
    logic [1:0]        idx;
    logic              found;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        src_d        = src_q;
        rr_d         = rr_q;
        in_pkt_d     = in_pkt_q;
        drop_d       = drop_q;
        busy_d       = busy_q;
        ip_suspend_d = ip_suspend_q;
        pop_vld_d    = '0;
        pop_sop_d    = '0;
        pop_eop_d    = '0;
        pop_data_d   = '{default: '0};
        head         = '{default: '0};
        empty        = '0;
        full         = '0;
        wr           = '0;
        pop          = '0;
        held         = drop_q;
        prev_ptr     = '0;
        idx          = '0;
        found        = 1'b0;

        for (int i = 0; i < NP; i++) begin
            head[i]  = mem_q[i][rd_ptr_q[i]];
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CW'(FIFO_DEPTH));
            if (drop_q[i] && !empty[i]) pop[i] = 1'b1;
        end

        // Granted egresses move one byte per clock into their pop stage
        for (int e = 0; e < NP; e++) begin
            if (busy_q[e]) begin
                held[src_q[e]] = 1'b1;
                if (!empty[src_q[e]] && !op_suspend[e]) begin
                    pop[src_q[e]] = 1'b1;
                    pop_vld_d[e]  = 1'b1;
                    pop_sop_d[e]  = head[src_q[e]][EW-1];
                    pop_eop_d[e]  = head[src_q[e]][DATA_W];
                    pop_data_d[e] = head[src_q[e]][DATA_W-1:0];
                    if (head[src_q[e]][DATA_W]) begin
                        busy_d[e] = 1'b0;
                        rr_d[e]   = src_q[e] + 2'd1;
                    end
                end
            end
        end

        for (int i = 0; i < NP; i++) begin
            if (drop_q[i] && pop[i] && head[i][DATA_W]) drop_d[i] = 1'b0;
            if (SELF_DROP && !held[i] && !empty[i] && head[i][EW-1] && head[i][1:0] == 2'(i))
                drop_d[i] = 1'b1;
        end

        // Idle egresses pick the first eligible header at or after their pointer
        for (int e = 0; e < NP; e++) begin
            found = 1'b0;
            if (!busy_q[e]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = 2'(int'(rr_q[e]) + k);
                    if (!found && !held[idx] && !empty[idx] && head[idx][EW-1] &&
                        head[idx][1:0] == 2'(e) && !(SELF_DROP && idx == 2'(e))) begin
                        found     = 1'b1;
                        busy_d[e] = 1'b1;
                        src_d[e]  = idx;
                    end
                end
            end
        end

        for (int i = 0; i < NP; i++) begin
            wr[i] = ip_valid[i] && !full[i] && (ip_sop[i] || in_pkt_q[i]);
            if (wr[i]) begin
                mem_d[i][wr_ptr_q[i]] = {ip_sop[i], ip_eop[i], ip_data[i*DATA_W +: DATA_W]};
                wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
                in_pkt_d[i] = !ip_eop[i];
                // A new header inside a packet closes the old one on its last stored byte
                if (ip_sop[i] && in_pkt_q[i] && !empty[i]) begin
                    prev_ptr = wr_ptr_q[i] - AW'(1);
                    mem_d[i][prev_ptr][DATA_W] = 1'b1;
                end
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            cnt_d[i]        = cnt_q[i] + CW'(wr[i]) - CW'(pop[i]);
            ip_suspend_d[i] = (cnt_d[i] >= CW'(FIFO_DEPTH - 2));
        end

        op_valid_d = pop_vld_q;
        op_sop_d   = pop_sop_q;
        op_eop_d   = pop_eop_q;
        op_data_d  = pop_data_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                cnt_q[i]      <= '0;
                src_q[i]      <= '0;
                rr_q[i]       <= '0;
                pop_data_q[i] <= '0;
                op_data_q[i]  <= '0;
            end
            in_pkt_q     <= '0;
            drop_q       <= '0;
            busy_q       <= '0;
            ip_suspend_q <= '0;
            pop_vld_q    <= '0;
            pop_sop_q    <= '0;
            pop_eop_q    <= '0;
            op_valid_q   <= '0;
            op_sop_q     <= '0;
            op_eop_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            rr_q         <= rr_d;
            pop_data_q   <= pop_data_d;
            op_data_q    <= op_data_d;
            in_pkt_q     <= in_pkt_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            ip_suspend_q <= ip_suspend_d;
            pop_vld_q    <= pop_vld_d;
            pop_sop_q    <= pop_sop_d;
            pop_eop_q    <= pop_eop_d;
            op_valid_q   <= op_valid_d;
            op_sop_q     <= op_sop_d;
            op_eop_q     <= op_eop_d;
        end
    end

    assign ip_suspend = ip_suspend_q;
    assign op_valid   = op_valid_q;
    assign op_sop     = op_sop_q;
    assign op_eop     = op_eop_q;

    always_comb begin
        op_data = '0;
        for (int e = 0; e < NP; e++) op_data[e*DATA_W +: DATA_W] = op_data_q[e];
    end

endmodule

// File: tb/tb_switch_port_4.sv
// Directed self-checking bench for switch_port_4: routing, latency, contention order,
// parallel flows, backpressure, self-route and asynchronous reset.
module tb_switch_port_4;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ip_valid, ip_sop, ip_eop, ip_suspend;
    logic [3:0]  op_valid, op_sop, op_eop, op_suspend;
    logic [31:0] ip_data, op_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [43:0] cap [$];   // {cycle, port, sop, eop, data}
    logic [9:0]  expq [$];  // {sop, eop, data}

    switch_port_4 #(.FIFO_DEPTH(16), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ip_valid   (ip_valid),
        .ip_sop     (ip_sop),
        .ip_eop     (ip_eop),
        .ip_data    (ip_data),
        .ip_suspend (ip_suspend),
        .op_valid   (op_valid),
        .op_sop     (op_sop),
        .op_eop     (op_eop),
        .op_data    (op_data),
        .op_suspend (op_suspend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 4; p++)
            if (op_valid[p])
                cap.push_back({32'(cyc), 2'(p), op_sop[p], op_eop[p], op_data[p*8 +: 8]});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_port(input int p);
        int n = 0;
        foreach (cap[j]) if (cap[j][11:10] == 2'(p)) n++;
        return n;
    endfunction

    function automatic logic [43:0] nth(input int p, input int k);
        int n = 0;
        logic [43:0] r = '1;
        foreach (cap[j]) begin
            if (cap[j][11:10] == 2'(p)) begin
                if (n == k) r = cap[j];
                n++;
            end
        end
        return r;
    endfunction

    task automatic chk_stream(input string tag, input int p);
        logic [43:0] e;
        chk({tag, "_len"}, 32'(count_port(p)), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            e = nth(p, k);
            chk($sformatf("%s_b%0d", tag, k), 32'(e[9:0]), 32'(expq[k]));
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                        input logic [31:0] d);
        ip_valid = v;
        ip_sop   = s;
        ip_eop   = e;
        ip_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        ip_valid = '0;
        ip_sop   = '0;
        ip_eop   = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        ip_valid   = '0;
        ip_sop     = '0;
        ip_eop     = '0;
        op_suspend = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cap.delete();
    endtask

    task automatic contention(input string tag);
        logic [43:0] a, b;
        cap.delete();
        step(4'b1011, 4'b1011, 4'b0000, {8'h0A, 8'h00, 8'h06, 8'h02});
        step(4'b1011, 4'b0000, 4'b0000, {8'hC0, 8'h00, 8'hB0, 8'hA0});
        step(4'b1011, 4'b0000, 4'b1011, {8'hC1, 8'h00, 8'hB1, 8'hA1});
        idle(30);
        expq = {10'h202, 10'h0A0, 10'h1A1, 10'h206, 10'h0B0, 10'h1B1, 10'h20A, 10'h0C0, 10'h1C1};
        chk_stream(tag, 2);
        for (int k = 0; k < 3; k++) begin
            a = nth(2, 3*k);
            b = nth(2, 3*k + 2);
            chk($sformatf("%s_contig%0d", tag, k), b[43:12] - a[43:12], 32'd2);
        end
    endtask

    initial begin
        logic [43:0] a;
        int sop_edge;
        int w;
        reset = 1'b0; ip_valid = '0; ip_sop = '0; ip_eop = '0; ip_data = '0; op_suspend = '0;
        @(negedge clk);
        chk("rst_op_valid", 32'(op_valid), 32'h0);
        chk("rst_op_sop", 32'(op_sop), 32'h0);
        chk("rst_op_eop", 32'(op_eop), 32'h0);
        chk("rst_op_data", op_data, 32'h0);
        chk("rst_ip_suspend", 32'(ip_suspend), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // single route 0 -> 2
        cap.delete();
        sop_edge = cyc + 1;
        step(4'b0001, 4'b0001, 4'b0000, 32'h02);
        step(4'b0001, 4'b0000, 4'b0000, 32'h11);
        step(4'b0001, 4'b0000, 4'b0000, 32'h22);
        step(4'b0001, 4'b0000, 4'b0001, 32'h33);
        idle(10);
        expq = {10'h202, 10'h011, 10'h022, 10'h133};
        chk_stream("route", 2);
        a = nth(2, 0);
        chk("route_latency", a[43:12], 32'(sop_edge + 3));
        a = nth(2, 3);
        chk("route_last_cycle", a[43:12], 32'(sop_edge + 6));
        chk("route_idle0", 32'(count_port(0)), 32'd0);
        chk("route_idle1", 32'(count_port(1)), 32'd0);
        chk("route_idle3", 32'(count_port(3)), 32'd0);

        // contention 0,1,3 -> 2, then a second round starting from pointer 0
        do_reset();
        contention("cont1");
        contention("cont2");

        // parallel 0->1, 1->2, 2->3, 3->0
        do_reset();
        sop_edge = cyc + 1;
        step(4'b1111, 4'b1111, 4'b0000, {8'h00, 8'h03, 8'h02, 8'h01});
        step(4'b1111, 4'b0000, 4'b0000, {8'h40, 8'h30, 8'h20, 8'h10});
        step(4'b1111, 4'b0000, 4'b0000, {8'h41, 8'h31, 8'h21, 8'h11});
        step(4'b1111, 4'b0000, 4'b1111, {8'h42, 8'h32, 8'h22, 8'h12});
        idle(10);
        expq = {10'h201, 10'h010, 10'h011, 10'h112};
        chk_stream("par_p1", 1);
        expq = {10'h202, 10'h020, 10'h021, 10'h122};
        chk_stream("par_p2", 2);
        expq = {10'h203, 10'h030, 10'h031, 10'h132};
        chk_stream("par_p3", 3);
        expq = {10'h200, 10'h040, 10'h041, 10'h142};
        chk_stream("par_p0", 0);
        for (int p = 0; p < 4; p++) begin
            a = nth(p, 0);
            chk($sformatf("par_start%0d", p), a[43:12], 32'(sop_edge + 3));
        end

        // backpressure: port0 streams 20 bytes to port3 while port3 is suspended
        do_reset();
        op_suspend = 4'b1000;
        for (int k = 0; k < 13; k++)
            step(4'b0001, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000, {24'h0, (k == 0) ? 8'h03 : 8'(k)});
        chk("bp_susp_at13", 32'(ip_suspend[0]), 32'd0);
        step(4'b0001, 4'b0000, 4'b0000, 32'h0D);
        chk("bp_susp_at14", 32'(ip_suspend[0]), 32'd1);
        idle(2);
        chk("bp_held_susp", 32'(ip_suspend[0]), 32'd1);
        chk("bp_no_egress", 32'(count_port(3)), 32'd0);
        op_suspend = 4'b0000;
        for (int k = 14; k < 20; k++) begin
            ip_valid = '0;
            w = 0;
            while (ip_suspend[0] && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("bp_wait_bound", 32'(w < 50), 32'd1);
            step(4'b0001, 4'b0000, (k == 19) ? 4'b0001 : 4'b0000, {24'h0, 8'(k)});
        end
        idle(40);
        expq.delete();
        expq.push_back(10'h203);
        for (int k = 1; k < 19; k++) expq.push_back({2'b00, 8'(k)});
        expq.push_back(10'h113);
        chk_stream("bp", 3);
        chk("bp_susp_final", 32'(ip_suspend[0]), 32'd0);

        // self route 1 -> 1, then a single-byte packet 1 -> 2
        do_reset();
        step(4'b0010, 4'b0010, 4'b0000, 32'h0000_0100);
        step(4'b0010, 4'b0000, 4'b0010, 32'h0000_AA00);
        idle(10);
`ifdef SELF_DROP_EN
        chk("self_dropped", 32'(count_port(1)), 32'd0);
`else
        expq = {10'h201, 10'h1AA};
        chk_stream("self_loop", 1);
`endif
        step(4'b0010, 4'b0010, 4'b0010, 32'h0000_0200);
        idle(10);
        expq = {10'h302};
        chk_stream("single_byte", 2);

        // asynchronous reset in the middle of traffic
        do_reset();
        op_suspend = 4'b1000;
        for (int k = 0; k < 14; k++)
            step(4'b0011, (k == 0) ? 4'b0011 : 4'b0000, 4'b0000,
                 {16'h0, (k == 0) ? 8'h00 : 8'(8'h50 + k), (k == 0) ? 8'h03 : 8'(k)});
        chk("mid_op_valid0", 32'(op_valid[0]), 32'd1);
        chk("mid_ip_susp0", 32'(ip_suspend[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_op_valid", 32'(op_valid), 32'h0);
        chk("arst_op_sop", 32'(op_sop), 32'h0);
        chk("arst_op_eop", 32'(op_eop), 32'h0);
        chk("arst_op_data", op_data, 32'h0);
        chk("arst_ip_suspend", 32'(ip_suspend), 32'h0);
        ip_valid = '0;
        ip_sop   = '0;
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b1;
        op_suspend = '0;
        cap.delete();
        idle(20);
        for (int p = 0; p < 4; p++)
            chk($sformatf("arst_empty%0d", p), 32'(count_port(p)), 32'd0);
        step(4'b0001, 4'b0001, 4'b0000, 32'h03);
        step(4'b0001, 4'b0000, 4'b0001, 32'h77);
        idle(10);
        expq = {10'h203, 10'h177};
        chk_stream("arst_restart", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
